// File: rtl/req_sequencer_pkg.sv
// Shared types and default sizing for the request sequencer.
// The entry record fixes the field order used by the table storage.
package req_sequencer_pkg;

    localparam int N_REQ_DEF   = 32;
    localparam int ADDR_W_DEF  = 10;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 255;
    localparam int CNT_W_DEF   = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [1:0] ST_IDLE = S_IDLE;
    localparam logic [1:0] ST_RUN  = S_RUN;
    localparam logic [1:0] ST_DONE = S_DONE;

    typedef struct packed {
        logic                  rw;
        logic                  chk;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } req_entry_t;

endpackage

// File: rtl/req_sequencer_if.sv
// Cache-side request/response bus between the sequencer (master) and a cache (slave).
interface req_sequencer_if #(
    parameter int ADDR_W = req_sequencer_pkg::ADDR_W_DEF,
    parameter int DATA_W = req_sequencer_pkg::DATA_W_DEF
);
    logic              req_valid;
    logic              req_rw;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              hit;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req_valid, req_rw, req_addr, req_wdata,
        input  hit, rdata
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata,
        output hit, rdata
    );
endinterface

// File: rtl/req_sequencer_table.sv
// Request table: synchronous write, asynchronous read, no reset so contents
// survive both runs and rst_n pulses.
module req_table
    import req_sequencer_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    localparam int IDX_W = $clog2(N_REQ)
)(
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic              wr_rw_i,
    input  logic              wr_chk_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic              rd_rw_o,
    output logic              rd_chk_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    output logic [DATA_W-1:0] rd_data_o
);
    localparam int ENTRY_W = 2 + ADDR_W + DATA_W;

    logic [ENTRY_W-1:0] mem_q [N_REQ];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= {wr_rw_i, wr_chk_i, wr_addr_i, wr_data_i};
        end
    end

    assign {rd_rw_o, rd_chk_o, rd_addr_o, rd_data_o} = mem_q[rd_idx_i];
endmodule

// File: rtl/req_sequencer.sv
// Replays a loaded table of read/write requests to a cache, one per accept,
// tracking stall cycles, read-compare errors and a per-request wait timeout.
//
// state | meaning
// IDLE  | after reset; table loads allowed, waiting for start
// RUN   | presenting table[cur_idx] to the cache until n_req accepts or timeout
// DONE  | run finished or aborted; table loads and restart allowed
module req_sequencer
    import req_sequencer_pkg::*;
#(
    parameter int N_REQ   = N_REQ_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    localparam int IDX_W  = $clog2(N_REQ)
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_en,
    input  logic [IDX_W-1:0]  ld_idx,
    input  logic              ld_rw,
    input  logic              ld_chk,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [IDX_W:0]    n_req,
    input  logic              start,
    req_sequencer_if.master   bus,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [IDX_W:0]    cur_idx,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  err_cnt
);
    localparam int CI_W  = IDX_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] WAIT_LOAD = TMR_W'(TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic [CI_W-1:0]  cur_idx_q, cur_idx_d;
    logic [CI_W-1:0]  n_q, n_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [TMR_W-1:0] wait_q, wait_d;
    logic             tmo_q, tmo_d;

    logic              e_rw, e_chk;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_data;
    logic              run;

    assign run = (state_q == ST_RUN);

    req_table #(
        .N_REQ  (N_REQ),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_table (
        .clk       (clk),
        .wr_en_i   (ld_en && !run),
        .wr_idx_i  (ld_idx),
        .wr_rw_i   (ld_rw),
        .wr_chk_i  (ld_chk),
        .wr_addr_i (ld_addr),
        .wr_data_i (ld_data),
        .rd_idx_i  (cur_idx_q[IDX_W-1:0]),
        .rd_rw_o   (e_rw),
        .rd_chk_o  (e_chk),
        .rd_addr_o (e_addr),
        .rd_data_o (e_data)
    );

    always_comb begin
        state_d   = state_q;
        cur_idx_d = cur_idx_q;
        n_d       = n_q;
        stall_d   = stall_q;
        err_d     = err_q;
        wait_d    = wait_q;
        tmo_d     = tmo_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    n_d       = n_req;
                    cur_idx_d = '0;
                    stall_d   = '0;
                    err_d     = '0;
                    tmo_d     = 1'b0;
                    wait_d    = WAIT_LOAD;
                    state_d   = (n_req == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.hit) begin
                    cur_idx_d = cur_idx_q + CI_W'(1);
                    wait_d    = WAIT_LOAD;
                    if (!e_rw && e_chk && (bus.rdata != e_data) && (err_q != '1)) begin
                        err_d = err_q + CNT_W'(1);
                    end
                    if (cur_idx_q == n_q - CI_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    if (stall_q != '1) begin
                        stall_d = stall_q + CNT_W'(1);
                    end
                    // Wait timer hits zero on the TIMEOUT-th consecutive stall.
                    if (wait_q == '0) begin
                        state_d = ST_DONE;
                        tmo_d   = 1'b1;
                    end else begin
                        wait_d = wait_q - TMR_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cur_idx_q <= '0;
            n_q       <= '0;
            stall_q   <= '0;
            err_q     <= '0;
            wait_q    <= WAIT_LOAD;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_idx_q <= cur_idx_d;
            n_q       <= n_d;
            stall_q   <= stall_d;
            err_q     <= err_d;
            wait_q    <= wait_d;
            tmo_q     <= tmo_d;
        end
    end

    // Fields are forced to zero outside RUN so unloaded entries never leak X.
    assign bus.req_valid = run;
    assign bus.req_rw    = run && e_rw;
    assign bus.req_addr  = run ? e_addr : '0;
    assign bus.req_wdata = run ? e_data : '0;

    assign busy      = run;
    assign done      = (state_q == ST_DONE);
    assign timeout   = tmo_q;
    assign cur_idx   = cur_idx_q;
    assign stall_cnt = stall_q;
    assign err_cnt   = err_q;
endmodule

// File: tb/tb_req_sequencer.sv
// Directed and randomized bench for req_sequencer against a per-run
// reference model built from the table contents and a planned stall schedule.
module tb_req_sequencer;
    import req_sequencer_pkg::*;

    localparam int N     = 32;
    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int TMO   = 8;
    localparam int CW    = 4;
    localparam int SAT   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ld_en = 1'b0;
    logic [4:0]    ld_idx = '0;
    logic          ld_rw = 1'b0;
    logic          ld_chk = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    logic [5:0]    n_req = '0;
    logic          start = 1'b0;
    logic          busy, done, timeout;
    logic [5:0]    cur_idx;
    logic [CW-1:0] stall_cnt, err_cnt;

    req_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    req_sequencer #(
        .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_en(ld_en), .ld_idx(ld_idx), .ld_rw(ld_rw), .ld_chk(ld_chk),
        .ld_addr(ld_addr), .ld_data(ld_data),
        .n_req(n_req), .start(start),
        .bus(bus.master),
        .busy(busy), .done(done), .timeout(timeout),
        .cur_idx(cur_idx), .stall_cnt(stall_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    req_entry_t    m_tab [N];
    int            stall_len [N];
    logic [DW-1:0] rd_val [N];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > SAT) ? SAT : v;
    endfunction

    task automatic load(input int idx, input bit rw, input bit chk,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
        ld_en = 1'b1; ld_idx = 5'(idx); ld_rw = rw; ld_chk = chk; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
        m_tab[idx] = '{rw: rw, chk: chk, addr: a, data: d};
    endtask

    task automatic plan_clean(input int n);
        for (int k = 0; k < n; k++) begin
            stall_len[k] = 0;
            rd_val[k]    = m_tab[k].data;
        end
    endtask

    // Checks the presented request against the model entry; optionally tries a table write mid-run.
    task automatic req_cycle(input int i, input bit poke);
        check("req_valid", bus.req_valid, 1);
        check("busy", busy, 1);
        check("cur_idx_run", cur_idx, i);
        check("req_rw", bus.req_rw, m_tab[i].rw);
        check("req_addr", bus.req_addr, m_tab[i].addr);
        if (m_tab[i].rw) check("req_wdata", bus.req_wdata, m_tab[i].data);
        if (poke) begin
            ld_en = 1'b1; ld_idx = '0; ld_rw = ~m_tab[0].rw; ld_chk = ~m_tab[0].chk;
            ld_addr = ~m_tab[0].addr; ld_data = ~m_tab[0].data;
        end
    endtask

    task automatic do_run(input int n, input bit poke);
        int  exp_stall, exp_err, i, s;
        bit  tmo, first;
        exp_stall = 0; exp_err = 0; i = 0; tmo = 1'b0; first = 1'b1;
        n_req = 6'(n); start = 1'b1; bus.hit = 1'($urandom); bus.rdata = $urandom;
        tick();
        start = 1'b0;
        while (i < n && !tmo) begin
            s = 0;
            while (!tmo && s < stall_len[i]) begin
                bus.hit = 1'b0; bus.rdata = $urandom;
                req_cycle(i, poke && first);
                first = 1'b0;
                tick();
                ld_en = 1'b0;
                exp_stall++; s++;
                if (s == TMO) tmo = 1'b1;
            end
            if (!tmo) begin
                bus.hit = 1'b1; bus.rdata = rd_val[i];
                req_cycle(i, poke && first);
                first = 1'b0;
                if (!m_tab[i].rw && m_tab[i].chk && rd_val[i] != m_tab[i].data) exp_err++;
                tick();
                ld_en = 1'b0;
                i++;
            end
        end
        bus.hit = 1'b0;
        check("done", done, 1);
        check("busy_end", busy, 0);
        check("req_valid_end", bus.req_valid, 0);
        check("timeout", timeout, tmo);
        check("cur_idx_end", cur_idx, tmo ? i : n);
        check("stall_cnt", stall_cnt, sat(exp_stall));
        check("err_cnt", err_cnt, sat(exp_err));
    endtask

    initial begin
        bus.hit = 1'b0; bus.rdata = '0;
        tick(); tick();
        check("rst_req_valid", bus.req_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_cur_idx", cur_idx, 0);
        check("rst_stall", stall_cnt, 0);
        check("rst_err", err_cnt, 0);
        rst_n = 1'b1;
        tick();

        // Basic three-entry run, then the same with four stalls on entry 1.
        load(0, 1'b0, 1'b1, 10'h014, 32'h0);
        load(1, 1'b1, 1'b0, 10'h02C, 32'h114514);
        load(2, 1'b0, 1'b1, 10'h02C, 32'h114514);
        plan_clean(3);
        do_run(3, 1'b0);
        stall_len[1] = 4;
        do_run(3, 1'b0);

        // Compare mismatch counted only when chk is set.
        load(0, 1'b0, 1'b1, 10'h030, 32'h1919);
        load(1, 1'b0, 1'b0, 10'h030, 32'h1919);
        plan_clean(2);
        rd_val[0] = 32'h1918; rd_val[1] = 32'h1918;
        do_run(2, 1'b0);

        // Timeout on entry 0, then a clean rerun.
        plan_clean(3);
        stall_len[0] = 20;
        do_run(3, 1'b0);
        plan_clean(3);
        do_run(3, 1'b0);

        // Stall counter saturation.
        plan_clean(3);
        stall_len[0] = 6; stall_len[1] = 6; stall_len[2] = 6;
        do_run(3, 1'b0);

        // Empty run.
        do_run(0, 1'b0);

        // Table write attempted during RUN must be ignored.
        plan_clean(2);
        stall_len[0] = 3;
        do_run(2, 1'b1);
        plan_clean(2);
        do_run(2, 1'b0);

        // Reset mid-run, then confirm the table survived.
        n_req = 6'd2; start = 1'b1; tick(); start = 1'b0;
        bus.hit = 1'b0; tick(); tick();
        rst_n = 1'b0; #1;
        check("midrst_req_valid", bus.req_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_cur_idx", cur_idx, 0);
        check("midrst_stall", stall_cnt, 0);
        tick();
        rst_n = 1'b1;
        tick();
        plan_clean(2);
        do_run(2, 1'b0);

        // Randomized runs.
        for (int r = 0; r < 10; r++) begin
            int n;
            n = $urandom_range(1, 16);
            for (int k = 0; k < n; k++) begin
                load(k, 1'($urandom), 1'($urandom), AW'($urandom), $urandom);
                stall_len[k] = ($urandom_range(0, 9) == 0) ? $urandom_range(TMO, TMO + 2)
                                                           : $urandom_range(0, 3);
                rd_val[k] = ($urandom_range(0, 1) == 1) ? m_tab[k].data : $urandom;
            end
            do_run(n, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
